shift_norm_pipe: RTL and testbench
==================================

SHIFT_NORM_PIPE -- requirements
Module: shift_norm_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, giving the operand width; legal values are even, 8..64.
REQ-002 The block SHALL have parameter SAW, default 5, giving the shift-amount width; the integrator sets SAW >= ceil(log2(WIDTH)).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operand is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand this cycle.
REQ-007 The block SHALL have port in_a, input, WIDTH bits: the operand to normalise.
REQ-008 The block SHALL have port in_even, input, 1 bit: 1 = even-granularity mode (sqrt path), 0 = full normalise.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port out_b, output, WIDTH bits: the normalised operand.
REQ-012 The block SHALL have port out_sa, output, SAW bits: the left-shift amount applied.
REQ-013 The block SHALL have port out_zero, output, 1 bit: the operand was all zeros.

Function
REQ-014 Transfer rules: input transfer occurs when in_valid & in_ready; output transfer occurs when out_valid & out_ready.
REQ-015 Even mode: out_sa = the largest even shift that leaves out_b[WIDTH-1:WIDTH-2] != 0; out_b = in_a << out_sa.
REQ-016 Full mode: out_sa = the leading-zero count of in_a; out_b[WIDTH-1] = 1.
REQ-017 Zero operand (either mode): out_zero = 1, out_b = 0, out_sa = 0; otherwise out_zero = 0.
REQ-018 Pipeline structure: two register stages.
  - Stage 1 registers the coarse shifts (16/8/4 and larger power-of-two steps for larger WIDTH), the partial shift amount, the mode and the zero flag.
  - Stage 2 registers the fine shifts (2, and 1 in full mode only) and the final outputs.
REQ-019 Latency and throughput: with out_ready held at 1, an operand accepted in cycle N SHALL appear with out_valid = 1 in cycle N+2; throughput is one operand per cycle.
REQ-020 Backpressure is elastic, with no bubbles:
  - A stage advances when it is empty or the stage downstream of it advances.
  - in_ready = ~s1_valid | s1_advance.
  - in_ready SHALL NOT depend on in_valid.
REQ-021 While out_valid = 1 and out_ready = 0, out_b, out_sa and out_zero SHALL hold stable.
REQ-022 Simultaneous events: when input and output transfers occur in the same cycle with both stages full, the pipeline SHALL shift both stages with no loss or duplication.
REQ-023 Results SHALL emerge in acceptance order; in_even is sampled per operand at acceptance.

Reset
REQ-024 While rst = 1 the block SHALL force all stage valid bits to 0, out_b = 0, out_sa = 0 and out_zero = 0.
REQ-025 While rst = 1, in_ready SHALL be 0; it SHALL rise in the first cycle after rst deasserts.
REQ-026 Reset mid-operation SHALL discard all in-flight operands; no result appears for them after reset.

Configuration
REQ-027 With macro SHIFT_NORM_PIPE_ZCNT_EN defined, the block SHALL add port zero_cnt, output, 16 bits.
  - zero_cnt counts input transfers with in_a = 0, saturating at 0xFFFF.
  - zero_cnt is reset to 0 by rst.
REQ-028 With SHIFT_NORM_PIPE_ZCNT_EN undefined, neither the port nor the counter SHALL exist, and all other behaviour SHALL be identical.

Verification (WIDTH=24, SAW=5)
REQ-029 in_a=0x000001, in_even=1 -> out_b=0x400000, out_sa=22, out_zero=0, two cycles after acceptance.
REQ-030 in_a=0x400000, in_even=0 -> out_b=0x800000, out_sa=1; same operand with in_even=1 -> out_b=0x400000, out_sa=0.
REQ-031 in_a=0x0000F0, in_even=1 -> out_b=0xF00000, out_sa=16; in_a=0 -> out_zero=1, out_b=0, out_sa=0, and zero_cnt increments by 1 when the macro is defined.
REQ-032 Backpressure: out_ready=0, in_valid=1 with three operands -> two operands accepted, in_ready=0 from the third cycle, out_* stable; raising out_ready -> the three results emerge in order, one per cycle.
REQ-033 Reset mid-operation: rst asserted with both stages full -> out_valid=0 immediately; after release no stale result appears and the next operand returns after two cycles.

Source files
------------

// File: rtl/shift_norm_pipe.sv
// Two-stage elastic normaliser: left-shifts an operand until its MSB (full mode)
// or top bit pair (even mode) is non-zero. Optional macro: SHIFT_NORM_PIPE_ZCNT_EN.
module shift_norm_pipe #(
  parameter int WIDTH = 24,
  parameter int SAW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic             in_even,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_b,
  output logic [SAW-1:0]   out_sa,
  output logic             out_zero
`ifdef SHIFT_NORM_PIPE_ZCNT_EN
  ,
  output logic [15:0]      zero_cnt
`endif
);

  localparam int LG = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] v;
    logic [SAW-1:0]   sa;
  } norm_t;

  // Power-of-two steps from the largest below WIDTH down to 4; all even,
  // so the same chain serves both modes.
  function automatic norm_t coarse_norm(input logic [WIDTH-1:0] a);
    norm_t r;
    r.v  = a;
    r.sa = '0;
    for (int i = LG - 1; i >= 2; i--) begin
      if ((r.v >> (WIDTH - (1 << i))) == '0) begin
        r.v  = r.v << (1 << i);
        r.sa = r.sa | (SAW'(1) << i);
      end
    end
    return r;
  endfunction

  // The 1-step only runs in full mode; a zero operand reports no shift.
  function automatic norm_t fine_norm(input logic [WIDTH-1:0] v, input logic [SAW-1:0] sa,
                                      input logic even, input logic zero);
    norm_t r;
    r.v  = v;
    r.sa = sa;
    if (r.v[WIDTH-1:WIDTH-2] == 2'b00) begin
      r.v  = r.v << 2;
      r.sa = r.sa | SAW'(2);
    end
    if (!even && !r.v[WIDTH-1]) begin
      r.v  = r.v << 1;
      r.sa = r.sa | SAW'(1);
    end
    if (zero) begin
      r.v  = '0;
      r.sa = '0;
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic             vld_p1, vld_p2;
  logic [WIDTH-1:0] a_p1;
  logic [SAW-1:0]   sa_p1;
  logic             even_p1, zero_p1;
  logic [WIDTH-1:0] b_p2;
  logic [SAW-1:0]   sa_p2;
  logic             zero_p2;

  logic  adv_p2, ld_p1, ld_p2;
  norm_t coarse_c, fine_c;

  assign adv_p2   = ~vld_p2 | out_ready;
  assign in_ready = ~rst & (~vld_p1 | adv_p2);
  assign ld_p1    = in_valid & in_ready;
  assign ld_p2    = adv_p2 & vld_p1;

  assign coarse_c = coarse_norm(in_a);
  assign fine_c   = fine_norm(a_p1, sa_p1, even_p1, zero_p1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (in_ready) vld_p1 <= in_valid;
      if (adv_p2)   vld_p2 <= vld_p1;
    end
  end

  // Stage 1: coarse shifts, partial shift amount, mode and zero flag
  always_ff @(posedge clk) begin
    if (ld_p1) begin
      a_p1    <= coarse_c.v;
      sa_p1   <= coarse_c.sa;
      even_p1 <= in_even;
      zero_p1 <= (in_a == '0);
    end
  end

  // Stage 2: fine shifts and final outputs, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_p2    <= '0;
      sa_p2   <= '0;
      zero_p2 <= 1'b0;
    end else if (ld_p2) begin
      b_p2    <= fine_c.v;
      sa_p2   <= fine_c.sa;
      zero_p2 <= zero_p1;
    end
  end

  assign out_valid = vld_p2;
  assign out_b     = b_p2;
  assign out_sa    = sa_p2;
  assign out_zero  = zero_p2;

`ifdef SHIFT_NORM_PIPE_ZCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_cnt <= '0;
    end else if (ld_p1 && (in_a == '0)) begin
      zero_cnt <= sat_inc16(zero_cnt);
    end
  end
`else
  logic [15:0] unused_sat;
  assign unused_sat = sat_inc16(16'd0);
`endif

endmodule

// File: tb/tb_shift_norm_pipe.sv
// Directed bench for shift_norm_pipe (WIDTH=24, SAW=5); inputs change and
// outputs are sampled on the falling edge.
module tb_shift_norm_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_even;
  logic [23:0] in_a;
  logic        out_valid, out_ready, out_zero;
  logic [23:0] out_b;
  logic [4:0]  out_sa;
`ifdef SHIFT_NORM_PIPE_ZCNT_EN
  logic [15:0] zero_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_norm_pipe #(.WIDTH(24), .SAW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_even   (in_even),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_b     (out_b),
    .out_sa    (out_sa),
    .out_zero  (out_zero)
`ifdef SHIFT_NORM_PIPE_ZCNT_EN
    ,
    .zero_cnt  (zero_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [23:0] b, input logic [4:0] sa, input logic z);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_b"},     {8'd0, out_b},      {8'd0, b});
    chk({tag, "_sa"},    {27'd0, out_sa},    {27'd0, sa});
    chk({tag, "_zero"},  {31'd0, out_zero},  {31'd0, z});
  endtask

  task automatic drive(input logic v, input logic [23:0] a, input logic e);
    in_valid = v;
    in_a     = a;
    in_even  = e;
  endtask

  initial begin
    rst = 1'b0; out_ready = 1'b1;
    drive(1'b0, 24'd0, 1'b0);
    #1 rst = 1'b1;

    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_b",     {8'd0, out_b},      32'd0);
    chk("rst_out_sa",    {27'd0, out_sa},    32'd0);
    chk("rst_out_zero",  {31'd0, out_zero},  32'd0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // single operand, even mode, latency two cycles
    drive(1'b1, 24'h000001, 1'b1);
    @(negedge clk);
    chk("lat_n1_valid", {31'd0, out_valid}, 32'd0);
    drive(1'b0, 24'd0, 1'b0);
    @(negedge clk);
    chk_out("one_even", 24'h400000, 5'd22, 1'b0);
    @(negedge clk);
    chk("one_even_drain", {31'd0, out_valid}, 32'd0);

    // back-to-back stream: full/even mode per operand, then a zero
    drive(1'b1, 24'h400000, 1'b0);
    @(negedge clk);
    drive(1'b1, 24'h400000, 1'b1);
    @(negedge clk);
    chk_out("s_full", 24'h800000, 5'd1, 1'b0);
    drive(1'b1, 24'h0000F0, 1'b1);
    @(negedge clk);
    chk_out("s_even", 24'h400000, 5'd0, 1'b0);
    drive(1'b1, 24'h000000, 1'b1);
    @(negedge clk);
    chk_out("s_f0", 24'hF00000, 5'd16, 1'b0);
    drive(1'b0, 24'd0, 1'b0);
    @(negedge clk);
    chk_out("s_zero", 24'h000000, 5'd0, 1'b1);
`ifdef SHIFT_NORM_PIPE_ZCNT_EN
    chk("zcnt_one", {16'd0, zero_cnt}, 32'd1);
`endif
    @(negedge clk);
    chk("s_drain", {31'd0, out_valid}, 32'd0);

    // backpressure: three offered, two taken, outputs held
    out_ready = 1'b0;
    drive(1'b1, 24'h000001, 1'b1);
    #1 chk("bp_rdy0", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("bp_rdy1", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 24'h400000, 1'b0);
    @(negedge clk);
    drive(1'b1, 24'h0000F0, 1'b1);
    #1 chk("bp_rdy2", {31'd0, in_ready}, 32'd0);
    chk_out("bp_hold0", 24'h400000, 5'd22, 1'b0);
    @(negedge clk);
    chk("bp_rdy3", {31'd0, in_ready}, 32'd0);
    chk_out("bp_hold1", 24'h400000, 5'd22, 1'b0);
    @(negedge clk);
    chk_out("bp_hold2", 24'h400000, 5'd22, 1'b0);
    out_ready = 1'b1;
    #1 chk("bp_rdy_release", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk_out("bp_r2", 24'h800000, 5'd1, 1'b0);
    drive(1'b0, 24'd0, 1'b0);
    @(negedge clk);
    chk_out("bp_r3", 24'hF00000, 5'd16, 1'b0);
    @(negedge clk);
    chk("bp_drain", {31'd0, out_valid}, 32'd0);

    // reset with both stages full
    out_ready = 1'b0;
    drive(1'b1, 24'h000001, 1'b1);
    @(negedge clk);
    drive(1'b1, 24'h000000, 1'b0);
    @(negedge clk);
    drive(1'b0, 24'd0, 1'b0);
    chk("mid_full_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready},  32'd0);
    chk("mid_rst_b",     {8'd0, out_b},      32'd0);
    chk("mid_rst_sa",    {27'd0, out_sa},    32'd0);
`ifdef SHIFT_NORM_PIPE_ZCNT_EN
    chk("mid_rst_zcnt",  {16'd0, zero_cnt},  32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("stale0", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("stale1", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 24'h000001, 1'b0);
    @(negedge clk);
    chk("post_n1_valid", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 24'h000000, 1'b0);
    @(negedge clk);
    chk_out("post_full", 24'h800000, 5'd23, 1'b0);
    drive(1'b0, 24'd0, 1'b0);
    @(negedge clk);
    chk_out("post_zero", 24'h000000, 5'd0, 1'b1);
`ifdef SHIFT_NORM_PIPE_ZCNT_EN
    chk("post_zcnt", {16'd0, zero_cnt}, 32'd1);
`endif
    @(negedge clk);
    chk("post_drain", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
